// File: rtl/mnist_frame_capture.sv
// Captures a 28x28 down-sampled VGA stream into a ping-pong pair of binarised frame banks.
// The capture side fills one bank while the classifier reads the other.
module mnist_frame_capture #(
  parameter int IMG_DIM    = 28,
  parameter int BIN_THRESH = 128,
  parameter int ADDR_W     = 10
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iCapture_en,
  input  logic              iStart_pixel,
  input  logic              iStart_stream,
  input  logic [4:0]        iSample_H_Cont,
  input  logic [4:0]        iSample_V_Cont,
  input  logic [7:0]        iBW,
  input  logic [ADDR_W-1:0] iRd_addr,
  output logic              oRd_data,
  output logic              oFrame_valid,
  input  logic              iFrame_ack,
  output logic              oBusy,
  output logic [15:0]       oFrame_count,
  output logic [7:0]        oDrop_count,
  output logic [7:0]        oErr_count
);

  localparam int FRAME = IMG_DIM * IMG_DIM;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME - 1);
  localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(FRAME);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOF,
    ARMED,
    CAPTURE,
    COMMIT
  } captureState_t;

  captureState_t state, nextState;

  logic              bankMem [2][FRAME];
  logic              wrBank, rdBank;
  logic              frameValid;
  logic [ADDR_W-1:0] expected, nextExpected;
  logic [15:0]       frameCount;
  logic [7:0]        dropCount, errCount;
  logic              rdData;

  logic              doWrite, errInc, doCommit, doDrop;
  logic [ADDR_W-1:0] sampleIdx;
  logic              pixelBit;
  logic              strobe;

  assign sampleIdx = (ADDR_W'(iSample_V_Cont) - ADDR_W'(1)) * ADDR_W'(IMG_DIM)
                   + ADDR_W'(iSample_H_Cont) - ADDR_W'(1);
  assign pixelBit  = (iBW >= 8'(BIN_THRESH));
  // A start-of-frame pulse masks any strobe that arrives with it.
  assign strobe    = iStart_stream && !iStart_pixel;

  always_comb begin
    nextState    = state;
    nextExpected = expected;
    doWrite      = 1'b0;
    errInc       = 1'b0;
    doCommit     = 1'b0;
    doDrop       = 1'b0;
    if (!iCapture_en) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:     nextState = WAIT_SOF;
        WAIT_SOF: if (iStart_pixel) nextState = ARMED;
        ARMED: begin
          if (strobe && iSample_H_Cont == 5'd1 && iSample_V_Cont == 5'd1) begin
            doWrite      = 1'b1;
            nextExpected = ADDR_W'(1);
            nextState    = CAPTURE;
          end
        end
        CAPTURE: begin
          if (iStart_pixel) begin
            errInc    = 1'b1;
            nextState = ARMED;
          end else if (iStart_stream) begin
            if (sampleIdx == expected) begin
              doWrite      = 1'b1;
              nextExpected = expected + ADDR_W'(1);
              if (sampleIdx == LAST_IDX) nextState = COMMIT;
            end else begin
              errInc    = 1'b1;
              nextState = WAIT_SOF;
            end
          end
        end
        COMMIT: begin
          if (!frameValid || iFrame_ack) doCommit = 1'b1;
          else                           doDrop   = 1'b1;
          nextState = WAIT_SOF;
        end
        default: nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state      <= IDLE;
      expected   <= '0;
      wrBank     <= 1'b0;
      rdBank     <= 1'b1;
      frameValid <= 1'b0;
      frameCount <= '0;
      dropCount  <= '0;
      errCount   <= '0;
      rdData     <= 1'b0;
    end else begin
      state    <= nextState;
      expected <= nextExpected;
      // A commit in the same cycle as an ack consumes the ack and keeps the frame valid.
      if (doCommit) begin
        wrBank     <= rdBank;
        rdBank     <= wrBank;
        frameValid <= 1'b1;
        frameCount <= frameCount + 16'd1;
      end else if (iFrame_ack) begin
        frameValid <= 1'b0;
      end
      if (doDrop && dropCount != 8'hFF) dropCount <= dropCount + 8'd1;
      if (errInc && errCount != 8'hFF)  errCount  <= errCount + 8'd1;
      rdData <= (iRd_addr < FRAME_SZ) ? bankMem[rdBank][iRd_addr] : 1'b0;
    end
  end

  // Bank storage has no reset so it can map onto block RAM.
  always_ff @(posedge iCLK) begin
    if (iRST_N && doWrite) bankMem[wrBank][sampleIdx] <= pixelBit;
  end

  assign oRd_data     = rdData;
  assign oFrame_valid = frameValid;
  assign oBusy        = (state == ARMED) || (state == CAPTURE);
  assign oFrame_count = frameCount;
  assign oDrop_count  = dropCount;
  assign oErr_count   = errCount;

endmodule

// File: tb/tb_mnist_frame_capture.sv
// Directed self-checking bench for mnist_frame_capture: commit, drop, ack, abort and threshold cases.
module tb_mnist_frame_capture;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic        iCapture_en;
  logic        iStart_pixel;
  logic        iStart_stream;
  logic [4:0]  iSample_H_Cont;
  logic [4:0]  iSample_V_Cont;
  logic [7:0]  iBW;
  logic [9:0]  iRd_addr;
  logic        oRd_data;
  logic        oFrame_valid;
  logic        iFrame_ack;
  logic        oBusy;
  logic [15:0] oFrame_count;
  logic [7:0]  oDrop_count;
  logic [7:0]  oErr_count;

  int checkCount = 0;
  int errorCount = 0;

  mnist_frame_capture dut (
    .iCLK           (iCLK),
    .iRST_N         (iRST_N),
    .iCapture_en    (iCapture_en),
    .iStart_pixel   (iStart_pixel),
    .iStart_stream  (iStart_stream),
    .iSample_H_Cont (iSample_H_Cont),
    .iSample_V_Cont (iSample_V_Cont),
    .iBW            (iBW),
    .iRd_addr       (iRd_addr),
    .oRd_data       (oRd_data),
    .oFrame_valid   (oFrame_valid),
    .iFrame_ack     (iFrame_ack),
    .oBusy          (oBusy),
    .oFrame_count   (oFrame_count),
    .oDrop_count    (oDrop_count),
    .oErr_count     (oErr_count)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // Pattern 0: checkerboard, 1: inverted checkerboard, 2: odd rows 128 / even rows 127.
  function automatic logic [7:0] pixelBw(input int pat, input int h, input int v);
    case (pat)
      0:       return ((h + v) % 2 == 0) ? 8'd255 : 8'd0;
      1:       return ((h + v) % 2 == 1) ? 8'd255 : 8'd0;
      default: return (v % 2 == 1) ? 8'd128 : 8'd127;
    endcase
  endfunction

  task automatic applyStimulus(input int h, input int v, input logic [7:0] bw);
    iStart_stream  = 1'b1;
    iSample_H_Cont = 5'(h);
    iSample_V_Cont = 5'(v);
    iBW            = bw;
    tick();
    iStart_stream  = 1'b0;
  endtask

  task automatic sendSof();
    iStart_pixel = 1'b1;
    tick();
    iStart_pixel = 1'b0;
  endtask

  task automatic sendRange(input int pat, input int first, input int last);
    for (int idx = first; idx <= last; idx++)
      applyStimulus(idx % 28 + 1, idx / 28 + 1, pixelBw(pat, idx % 28 + 1, idx / 28 + 1));
  endtask

  task automatic pulseAck();
    iFrame_ack = 1'b1;
    tick();
    iFrame_ack = 1'b0;
  endtask

  task automatic readCheck(input string tag, input int addr, input logic expected);
    iRd_addr = 10'(addr);
    tick();
    checkOutput(tag, {31'd0, oRd_data}, {31'd0, expected});
  endtask

  initial begin
    iRST_N = 1'b0; iCapture_en = 1'b0; iStart_pixel = 1'b0; iStart_stream = 1'b0;
    iSample_H_Cont = '0; iSample_V_Cont = '0; iBW = '0; iRd_addr = '0; iFrame_ack = 1'b0;
    repeat (3) tick();
    checkOutput("rst_valid", oFrame_valid, 0);
    checkOutput("rst_fcount", oFrame_count, 0);
    checkOutput("rst_drop", oDrop_count, 0);
    checkOutput("rst_err", oErr_count, 0);
    checkOutput("rst_busy", oBusy, 0);
    checkOutput("rst_rdata", oRd_data, 0);
    iRST_N = 1'b1;

    // First ordered frame commits into the read bank.
    iCapture_en = 1'b1;
    tick();
    sendSof();
    checkOutput("armed_busy", oBusy, 1);
    sendRange(0, 0, 783);
    tick(); tick();
    checkOutput("f1_valid", oFrame_valid, 1);
    checkOutput("f1_fcount", oFrame_count, 1);
    checkOutput("f1_busy", oBusy, 0);
    readCheck("f1_rd0", 0, 1'b1);
    readCheck("f1_rd1", 1, 1'b0);
    readCheck("f1_rd29", 29, 1'b1);
    readCheck("f1_rd783", 783, 1'b1);
    readCheck("f1_rd800", 800, 1'b0);

    // Second frame without ack is dropped.
    sendSof();
    sendRange(1, 0, 783);
    tick(); tick();
    checkOutput("drop_cnt", oDrop_count, 1);
    checkOutput("drop_fcount", oFrame_count, 1);
    readCheck("drop_rd0", 0, 1'b1);
    pulseAck();
    checkOutput("ack_valid", oFrame_valid, 0);
    sendSof();
    sendRange(1, 0, 783);
    tick(); tick();
    checkOutput("f3_fcount", oFrame_count, 2);
    checkOutput("f3_valid", oFrame_valid, 1);
    readCheck("f3_rd0", 0, 1'b0);
    readCheck("f3_rd1", 1, 1'b1);

    // Ack in the commit cycle.
    sendSof();
    sendRange(0, 0, 783);
    iFrame_ack = 1'b1;
    tick();
    iFrame_ack = 1'b0;
    checkOutput("ackcommit_valid", oFrame_valid, 1);
    checkOutput("ackcommit_fcount", oFrame_count, 3);
    checkOutput("ackcommit_drop", oDrop_count, 1);
    readCheck("ackcommit_rd0", 0, 1'b1);

    // Skipped sample index aborts the frame.
    pulseAck();
    sendSof();
    sendRange(1, 0, 99);
    sendRange(1, 101, 101);
    tick();
    checkOutput("skip_err", oErr_count, 1);
    checkOutput("skip_busy", oBusy, 0);
    checkOutput("skip_fcount", oFrame_count, 3);
    sendSof();
    sendRange(1, 0, 783);
    tick(); tick();
    checkOutput("skipnext_fcount", oFrame_count, 4);
    readCheck("skipnext_rd0", 0, 1'b0);

    // Start-of-frame in the middle of a capture truncates it.
    pulseAck();
    sendSof();
    sendRange(0, 0, 399);
    sendSof();
    checkOutput("trunc_err", oErr_count, 2);
    checkOutput("trunc_busy", oBusy, 1);
    sendRange(0, 0, 783);
    tick(); tick();
    checkOutput("truncnext_fcount", oFrame_count, 5);
    readCheck("truncnext_rd1", 1, 1'b0);

    // Capture enable dropped mid-frame, then a threshold-boundary frame.
    pulseAck();
    sendSof();
    sendRange(1, 0, 199);
    iCapture_en = 1'b0;
    tick();
    checkOutput("dis_busy", oBusy, 0);
    checkOutput("dis_err", oErr_count, 2);
    checkOutput("dis_fcount", oFrame_count, 5);
    iCapture_en = 1'b1;
    tick();
    sendSof();
    sendRange(2, 0, 783);
    tick(); tick();
    checkOutput("thr_fcount", oFrame_count, 6);
    checkOutput("thr_valid", oFrame_valid, 1);
    readCheck("thr_rd0_128", 0, 1'b1);
    readCheck("thr_rd1_128", 1, 1'b1);
    readCheck("thr_rd28_127", 28, 1'b0);
    readCheck("thr_rd29_127", 29, 1'b0);
    checkOutput("final_drop", oDrop_count, 1);
    checkOutput("final_err", oErr_count, 2);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/mnist_frame_capture.md
Name: mnist_frame_capture

Overview:
- Consumer end of the VGA down-sample stream: accepts the per-sample strobe, 28x28 sample coordinates and BW pixel from the VGA controller, and assembles one binarised 784-pixel MNIST frame.
- Ping-pong buffered: one bank is written by the capture side while the other is held stable for the classifier to read.
- Sits between the VGA controller and the classifier input stage.

Parameters:
- IMG_DIM, 28, image side in samples; frame size is IMG_DIM*IMG_DIM = 784.
- BIN_THRESH, 128, a pixel is stored as 1 when iBW >= BIN_THRESH, otherwise as 0.
- ADDR_W, 10, width of the read address.

Ports:
- iCLK  in  1  pixel clock, the same clock as the VGA controller.
- iRST_N  in  1  reset, synchronous and active-low.
- iCapture_en  in  1  capture enable; when low the capture side is held in IDLE.
- iStart_pixel  in  1  start-of-frame pulse, one cycle long.
- iStart_stream  in  1  sample strobe, one cycle long.
- iSample_H_Cont  in  5  column of the current sample, 1..28, valid while iStart_stream is high.
- iSample_V_Cont  in  5  row of the current sample, 1..28, valid while iStart_stream is high.
- iBW  in  8  pixel value, valid while iStart_stream is high.
- iRd_addr  in  ADDR_W  classifier read address, row-major, 0..783.
- oRd_data  out  1  stored pixel bit, 1-cycle read latency.
- oFrame_valid  out  1  the read bank holds a complete frame that has not been acknowledged.
- iFrame_ack  in  1  classifier has finished with the read bank; single-cycle pulse.
- oBusy  out  1  high in the ARMED and CAPTURE states.
- oFrame_count  out  16  number of committed frames; wraps.
- oDrop_count  out  8  frames completed while the read bank was still held; saturates at 255.
- oErr_count  out  8  aborted or misordered frames; saturates at 255.

Behaviour:
- Reset (iRST_N low at a clock edge): all outputs go to 0, the state goes to IDLE, the write bank is 0 and the read bank is 1. Bank contents are not cleared.
- Sample index: idx = (V-1)*IMG_DIM + (H-1). The stored bit is (iBW >= BIN_THRESH).
- States and transitions:
  - IDLE: go to WAIT_SOF when iCapture_en is high.
  - WAIT_SOF: go to ARMED on iStart_pixel.
  - ARMED: on a strobe with H=1 and V=1, write idx 0, set expected=1 and go to CAPTURE. Any other strobe is ignored without counting an error.
  - CAPTURE: on a strobe with idx==expected, write the bit and increment expected. When the write is to idx 783, go to COMMIT. On a strobe with idx!=expected, increment oErr_count and go to WAIT_SOF.
  - CAPTURE, iStart_pixel before completion: this is a truncated frame. Increment oErr_count and go to ARMED.
  - COMMIT (one cycle): if oFrame_valid is 0, or iFrame_ack is high in this same cycle, swap the banks, hold oFrame_valid at 1 and increment oFrame_count. Otherwise discard the write bank contents and increment oDrop_count. In both cases go to WAIT_SOF.
- Simultaneous events:
  - iStart_pixel and iStart_stream together: iStart_pixel wins and the strobe is ignored.
  - ack and commit in the same cycle: the ack is consumed, the new frame is committed and oFrame_valid stays 1.
- iCapture_en deasserted in any state: go to IDLE on the next edge, abandon any partial frame, no error counted. The read side (oFrame_valid, read bank) is unaffected.
- Read side:
  - oRd_data is registered: data for iRd_addr sampled at edge N appears after edge N.
  - Addresses >= 784 return 0.
  - The read bank never changes while oFrame_valid=1 unless iFrame_ack is accepted.
- Ack handling: iFrame_ack clears oFrame_valid on the next edge. An ack while oFrame_valid=0 is ignored.
- Counters: oErr_count and oDrop_count saturate at 255. oFrame_count wraps at 65535->0.

Test Plan:
- Reset, then a full ordered frame (pixel = 255 at idx where (H+V) is even, else 0) -> after the (28,28) strobe plus 2 cycles: oFrame_valid=1, oFrame_count=1; reading addr 0 returns 1 and addr 1 returns 0, each one cycle after the address is applied; addr 800 returns 0.
- A second frame completes without an ack -> oDrop_count=1, oFrame_count stays 1, read data unchanged. Then pulse the ack and send a third frame -> oFrame_count=2 with the new data.
- iFrame_ack asserted in the same cycle as COMMIT -> oFrame_valid stays 1, oFrame_count increments, the new frame is readable.
- A strobe skipping idx 100 (sending 101) -> oErr_count=1, no commit. The next full frame after iStart_pixel commits normally.
- iStart_pixel at sample 400 -> oErr_count increments and the state returns to ARMED. The following complete frame commits.
- iCapture_en dropped mid-frame -> oBusy=0 next cycle, counters unchanged. Re-enable followed by a full frame -> commit. BIN_THRESH boundary: iBW=127 stores 0, iBW=128 stores 1.
